// File: rtl/fft_ana_pkg.sv
// Shared constants and state types for the FFT peak analyser.
package fft_ana_pkg;
    localparam int DW       = 16;
    localparam int NBIN     = 16;
    localparam int LANES    = 2;
    localparam int MAG_W    = 2 * DW;
    localparam int SCAN_CYC = NBIN / LANES;
    localparam int IDX_W    = $clog2(NBIN);
    localparam int SIDX_W   = $clog2(SCAN_CYC);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
    typedef enum logic {REAL, IMAG} phase_t;
endpackage

// File: rtl/fft_mag_sq.sv
// One scan lane: registered re^2 + im^2 of a signed complex sample.
module fft_mag_sq
    import fft_ana_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic [MAG_W-1:0]     mag
);
    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;

    // Each square is at most 2^30, so the sum always fits unsigned MAG_W.
    always_comb begin
        re_sq = MAG_W'(re) * MAG_W'(re);
        im_sq = MAG_W'(im) * MAG_W'(im);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mag <= '0;
        else     mag <= $unsigned(re_sq + im_sq);
    end
endmodule

// File: rtl/fft_peak_analysis.sv
// Per-frame argmax of |X[k]|^2 over the FFT's two-beat (real, imag) output.
// state | meaning
// IDLE  | waiting for the imaginary beat of a frame
// SCAN  | squaring LANES bins per cycle, folding the previous pair into the max
// FLUSH | folding the last pair and publishing freq/peak_mag
module fft_peak_analysis
    import fft_ana_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_valid,
    input  logic [DW-1:0]    fft_d0,  fft_d1,  fft_d2,  fft_d3,
    input  logic [DW-1:0]    fft_d4,  fft_d5,  fft_d6,  fft_d7,
    input  logic [DW-1:0]    fft_d8,  fft_d9,  fft_d10, fft_d11,
    input  logic [DW-1:0]    fft_d12, fft_d13, fft_d14, fft_d15,
    input  logic             fft_done,
    output logic             freq_valid,
    output logic [IDX_W-1:0] freq,
    output logic [MAG_W-1:0] peak_mag,
    output logic             overflow,
    output logic             done
);
    logic signed [DW-1:0] d_in    [NBIN];
    logic signed [DW-1:0] re_buf  [NBIN];
    logic signed [DW-1:0] im_buf  [NBIN];
    logic signed [DW-1:0] scan_re [NBIN];
    logic [MAG_W-1:0]     lane_mag [LANES];

    state_t            state;
    phase_t            phase;
    logic [SIDX_W-1:0] scan_idx, cmp_base;
    logic              cmp_valid, done_lat;
    logic [MAG_W-1:0]  run_mag, best_mag;
    logic [IDX_W-1:0]  run_idx, best_idx;
    logic              imag_beat;

    assign d_in[0]  = fft_d0;  assign d_in[1]  = fft_d1;  assign d_in[2]  = fft_d2;
    assign d_in[3]  = fft_d3;  assign d_in[4]  = fft_d4;  assign d_in[5]  = fft_d5;
    assign d_in[6]  = fft_d6;  assign d_in[7]  = fft_d7;  assign d_in[8]  = fft_d8;
    assign d_in[9]  = fft_d9;  assign d_in[10] = fft_d10; assign d_in[11] = fft_d11;
    assign d_in[12] = fft_d12; assign d_in[13] = fft_d13; assign d_in[14] = fft_d14;
    assign d_in[15] = fft_d15;

    assign imag_beat = fft_valid && (phase == IMAG);

    // Data buffers carry no reset; their contents only matter once a frame is loaded.
    always_ff @(posedge clk) begin
        if (fft_valid) begin
            if (phase == REAL) begin
                re_buf <= d_in;
            end else begin
                im_buf  <= d_in;
                scan_re <= re_buf;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] sel;
        assign sel = IDX_W'(int'(scan_idx) * LANES + l);
        fft_mag_sq u_mag (
            .clk (clk),
            .rst (rst),
            .re  (scan_re[sel]),
            .im  (im_buf[sel]),
            .mag (lane_mag[l])
        );
    end

    // Lanes are visited in ascending bin order with a strict compare, so ties keep the lowest index.
    always_comb begin
        best_mag = run_mag;
        best_idx = run_idx;
        for (int l = 0; l < LANES; l++) begin
            if (lane_mag[l] > best_mag) begin
                best_mag = lane_mag[l];
                best_idx = IDX_W'(int'(cmp_base) * LANES + l);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= REAL;
            scan_idx   <= '0;
            cmp_base   <= '0;
            cmp_valid  <= 1'b0;
            run_mag    <= '0;
            run_idx    <= '0;
            freq_valid <= 1'b0;
            freq       <= '0;
            peak_mag   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            done_lat   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            cmp_base   <= scan_idx;
            cmp_valid  <= (state == SCAN);
            if (fft_done)  done_lat <= 1'b1;
            if (fft_valid) phase    <= (phase == REAL) ? IMAG : REAL;

            if (imag_beat) begin
                state     <= SCAN;
                scan_idx  <= '0;
                run_mag   <= '0;
                run_idx   <= '0;
                cmp_valid <= 1'b0;
                if (state != IDLE) overflow <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (done_lat && phase == REAL && !fft_valid) done <= 1'b1;
                    end
                    SCAN: begin
                        if (cmp_valid) begin
                            run_mag <= best_mag;
                            run_idx <= best_idx;
                        end
                        if (scan_idx == SIDX_W'(SCAN_CYC - 1)) state <= FLUSH;
                        else                                    scan_idx <= scan_idx + 1'b1;
                    end
                    FLUSH: begin
                        freq       <= best_idx;
                        peak_mag   <= best_mag;
                        freq_valid <= 1'b1;
                        state      <= IDLE;
                        if (done_lat && phase == REAL && !fft_valid) done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/fft_peak_analysis.md
# fft_peak_analysis

Downstream consumer of the FFT stage. Takes the FFT's two-beat frame output (beat 1: 16 real parts, beat 2: 16 imaginary parts, on `fft_d0..fft_d15` qualified by `fft_valid`), computes |X[k]|² for all 16 bins and reports the index and energy of the strongest bin per frame. Signals `done` once the final frame has been reported after the FFT asserts its own `done`.

## Interface
- `DW`, 16: sample width; signed two's complement, same format as the FFT outputs.
- `NBIN`, 16: bins per frame; fixed at 16.
- `LANES`, 2: bins evaluated per scan cycle; `NBIN/LANES` scan cycles per frame.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fft_valid`  in  1  a beat is present on `fft_d*` this cycle.
- `fft_d0`..`fft_d15`  in  DW each  bin k value: real on the first beat of a pair, imaginary on the second.
- `fft_done`  in  1  FFT has emitted its last frame (the FFT's `done`); may be a pulse or a level.
- `freq_valid`  out  1  one-cycle pulse; `freq`/`peak_mag` are valid.
- `freq`  out  4  index of the maximum-energy bin.
- `peak_mag`  out  2*DW  re²+im² of that bin, unsigned.
- `overflow`  out  1  sticky; a frame arrived while a scan was in progress.
- `done`  out  1  sticky; all frames reported after `fft_done`.

## Operation
- Reset: all outputs 0; beat phase = REAL; state IDLE; buffers are don't-care.
- Beat phase toggles on every `fft_valid`. REAL beat: load `re_buf[0..15]`. IMAG beat: load `im_buf`, copy `re_buf` into the scan buffer, clear running max (mag 0, idx 0), set `scan_idx` = 0, enter SCAN.
- States: IDLE → SCAN (on IMAG beat) → FLUSH (after `scan_idx` = NBIN/LANES−1) → IDLE.
- SCAN: each cycle registers re²+im² for bins {LANES·scan_idx .. LANES·scan_idx+LANES−1}; the compare stage folds the previous cycle's squares into the running max one cycle later.
- FLUSH: folds the last pair, registers `freq`, `peak_mag`, pulses `freq_valid`.
- Arithmetic: signed DW×DW squares; sum fits 2*DW unsigned (max 2·2^30). Compare is strictly greater: on ties the lowest index wins. An all-zero frame reports `freq`=0, `peak_mag`=0.
- An IMAG beat during SCAN/FLUSH: aborts the current frame (no `freq_valid` for it), restarts the scan on the new frame, sets `overflow`.
- A REAL beat during SCAN: only updates `re_buf`; the scan buffer is untouched, so the scan continues undisturbed.
- `fft_done` is latched. `done` rises at the edge of the final `freq_valid` when the latch is set and the beat phase is REAL (no half frame pending); if already IDLE when `fft_done` is latched, `done` rises on the next edge. Held until reset.
- `rst` mid-scan: immediate return to reset state; no result emitted.

## Timing
- IMAG beat sampled at edge T; squares registered at edges T+1..T+8; compares at T+2..T+9; `freq_valid` high from edge T+9 to T+10.
- Latency is 9 cycles from the IMAG beat to the result. Frames need ≥10 cycles between IMAG beats to avoid `overflow`. The FFT's nominal spacing of 16 cycles meets this.
- `freq`/`peak_mag` hold their last value between pulses.

## Structure
- Package `fft_ana_pkg`: `DW`, `NBIN`, `LANES`, `MAG_W` = 2*DW, `SCAN_CYC` = NBIN/LANES, state enum {IDLE, SCAN, FLUSH}, beat-phase enum {REAL, IMAG}.
- Sub-module `fft_mag_sq`: one lane; registered signed re²+im² output. Instantiate `LANES` times.
- Top level holds the buffers, FSM, argmax compare and the done logic.

## Test plan
- Single frame, all bins 0 except re[5]=0x0100, im[5]=0x0100 → `freq_valid` at T+9, `freq`=5, `peak_mag`=0x00020000.
- Tie: re[3]=re[12]=0x0200, everything else 0 → `freq`=3, `peak_mag`=0x00040000.
- Negative extreme: re[15]=0x8000, im[15]=0x8000 → `freq`=15, `peak_mag`=0x80000000; all-zero frame → `freq`=0, `peak_mag`=0.
- Second IMAG beat 5 cycles after the first → first frame produces no pulse; second frame reported at its T+9; `overflow`=1 until reset.
- 64 frames at 16-cycle spacing, `fft_done` after the last pair → 64 `freq_valid` pulses matching the golden argmax; `done` rises at the 64th pulse; `overflow`=0.
- `rst` asserted at T+4 of a scan → all outputs 0 immediately; the next REAL/IMAG pair is processed normally.
